// File: rtl/blink_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// default timing parameters (sized for a 100 MHz system clock).
package blink_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 100_000_000;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_e;

endpackage

// File: rtl/button_debounce_sync2.sv
// Two-flop synchronizer that brings one asynchronous bit into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: accepts a level change only after the synchronized input
// has been stable for DEBOUNCE_CYCLES, and flags holds that last LONG_CYCLES.
module button_debounce
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] LONG_SAT  = 32'(LONG_CYCLES);

    logic btn_sync;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    btn_state_e  state_q,    state_d;
    logic [31:0] deb_cnt_q,  deb_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        level_q,    level_d;
    logic        press_q,    press_d;
    logic        release_q,  release_d;
    logic        long_q,     long_d;
    logic [7:0]  count_q,    count_d;
    logic        hold_run;

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        count_d    = count_q;
        hold_run   = 1'b0;

        case (state_q)
            RELEASED: begin
                if (btn_sync) begin
                    state_d   = PRESS_CHK;
                    deb_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync) begin
                    state_d = RELEASED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    count_d    = count_q + 8'd1;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 32'd1;
                end
            end
            PRESSED: begin
                hold_run = 1'b1;
                if (!btn_sync) begin
                    state_d   = RELEASE_CHK;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_CHK: begin
                // The hold keeps timing through a release glitch; only an
                // accepted release stops it, so long_press never collides with it.
                if (btn_sync) begin
                    state_d  = PRESSED;
                    hold_run = 1'b1;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 32'd1;
                    hold_run  = 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase

        if (hold_run) begin
            if (hold_cnt_q != LONG_SAT) begin
                hold_cnt_d = hold_cnt_q + 32'd1;
            end
            if (hold_cnt_q == LONG_LAST) begin
                long_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RELEASED;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            count_q    <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with short timing parameters.
module tb_button_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_raw = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;

    int checks_total  = 0;
    int checks_passed = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // Reference model: the input is delayed two samples, the level flips after
    // DEB+1 consecutive samples that disagree with it, and a long press fires
    // LONG edges after the accepted press while the level is still high.
    logic       m_s1, m_s2, m_s;
    logic       m_lvl, m_press, m_rel, m_long;
    logic [7:0] m_cnt;
    int         m_run, m_since;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0;
            m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
            m_cnt = 8'd0; m_run = 0; m_since = 0;
        end else begin
            m_s  = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_raw;
            m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
            if (m_s != m_lvl) m_run = m_run + 1;
            else m_run = 0;
            if (m_run == DEB + 1) begin
                m_run = 0;
                m_lvl = m_s;
                if (m_s) begin
                    m_press = 1'b1;
                    m_cnt   = m_cnt + 8'd1;
                    m_since = 0;
                end else begin
                    m_rel = 1'b1;
                end
            end else if (m_lvl) begin
                m_since = m_since + 1;
                if (m_since == LONG) m_long = 1'b1;
            end
        end
    end

    logic [11:0] dut_vec, exp_vec;
    assign dut_vec = {btn_level, press_pulse, release_pulse, long_press, press_count};
    assign exp_vec = {m_lvl, m_press, m_rel, m_long, m_cnt};

    // Driver: apply one raw sample, then wait to the next sampling point.
    task automatic step(input logic raw);
        btn_raw = raw;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step(1'b1);
        checks_total++;
        if (dut_vec !== 12'h000)
            $display("FAIL reset_outputs got %h expected %h", dut_vec, 12'h000);
        else checks_passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            checks_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL reset_idle got %h expected %h", dut_vec, exp_vec);
            else checks_passed++;
        end
    endtask

    task automatic test_clean_press();
        int lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1);
            checks_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL clean_model got %h expected %h", dut_vec, exp_vec);
            else checks_passed++;
            if (press_pulse && lat < 0) lat = i - 1;
        end
        checks_total++;
        if (lat !== DEB + 2) $display("FAIL clean_press_latency got %0d expected %0d", lat, DEB + 2);
        else checks_passed++;
        checks_total++;
        if (btn_level !== 1'b1) $display("FAIL clean_level got %b expected 1", btn_level);
        else checks_passed++;
        checks_total++;
        if (press_count !== 8'd1) $display("FAIL clean_count got %0d expected 1", press_count);
        else checks_passed++;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0);
            checks_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL clean_rel_model got %h expected %h", dut_vec, exp_vec);
            else checks_passed++;
            if (release_pulse && lat < 0) lat = i - 1;
        end
        checks_total++;
        if (lat !== DEB + 2) $display("FAIL clean_release_latency got %0d expected %0d", lat, DEB + 2);
        else checks_passed++;
    endtask

    task automatic test_bounce();
        int n = 0;
        logic seen = 1'b0;
        while (n < 30) begin
            int hi = $urandom_range(1, 3);
            int lo = $urandom_range(1, 3);
            for (int i = 0; i < hi + lo; i++) begin
                step(i < hi);
                n++;
                checks_total++;
                if (dut_vec !== exp_vec)
                    $display("FAIL bounce_model got %h expected %h", dut_vec, exp_vec);
                else checks_passed++;
                if (press_pulse || btn_level) seen = 1'b1;
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            if (press_pulse || btn_level) seen = 1'b1;
        end
        checks_total++;
        if (seen !== 1'b0) $display("FAIL bounce_rejected got %b expected 0", seen);
        else checks_passed++;
    endtask

    task automatic test_long_press();
        int press_at = -1, long_at = -1, long_n = 0, lat = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1);
            checks_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL long_model got %h expected %h", dut_vec, exp_vec);
            else checks_passed++;
            if (press_pulse) press_at = i;
            if (long_press) begin long_at = i; long_n++; end
        end
        checks_total++;
        if (long_n !== 1) $display("FAIL long_count got %0d expected 1", long_n);
        else checks_passed++;
        checks_total++;
        if (long_at - press_at !== LONG)
            $display("FAIL long_delay got %0d expected %0d", long_at - press_at, LONG);
        else checks_passed++;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0);
            if (release_pulse && lat < 0) lat = i - 1;
        end
        checks_total++;
        if (lat !== DEB + 2) $display("FAIL long_release_latency got %0d expected %0d", lat, DEB + 2);
        else checks_passed++;
    endtask

    task automatic test_release_glitch();
        int press_at = -1, long_at = -1, long_n = 0;
        logic rel_seen = 1'b0, drop_seen = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            step(!(i == 13 || i == 14));
            checks_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL glitch_model got %h expected %h", dut_vec, exp_vec);
            else checks_passed++;
            if (press_pulse) press_at = i;
            if (long_press) begin long_at = i; long_n++; end
            if (release_pulse) rel_seen = 1'b1;
            if (press_at > 0 && !btn_level) drop_seen = 1'b1;
        end
        checks_total++;
        if (rel_seen !== 1'b0) $display("FAIL glitch_no_release got %b expected 0", rel_seen);
        else checks_passed++;
        checks_total++;
        if (drop_seen !== 1'b0) $display("FAIL glitch_level_held got %b expected 0", drop_seen);
        else checks_passed++;
        checks_total++;
        if (long_n !== 1 || long_at - press_at !== LONG)
            $display("FAIL glitch_long got n=%0d delay=%0d expected n=1 delay=%0d",
                     long_n, long_at - press_at, LONG);
        else checks_passed++;
        repeat (12) step(1'b0);
    endtask

    task automatic test_wrap();
        int pulses = 0;
        rst_n = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < 16; i++) begin
                step(i < 8);
                checks_total++;
                if (dut_vec !== exp_vec)
                    $display("FAIL wrap_model got %h expected %h", dut_vec, exp_vec);
                else checks_passed++;
                if (press_pulse) pulses++;
            end
        end
        checks_total++;
        if (pulses !== 257) $display("FAIL wrap_pulses got %0d expected 257", pulses);
        else checks_passed++;
        checks_total++;
        if (press_count !== 8'd1) $display("FAIL wrap_count got %0d expected 1", press_count);
        else checks_passed++;
    endtask

    task automatic test_reset_mid_hold();
        int lat = -1, guard = 0;
        logic rel_seen = 1'b0;
        while (!press_pulse && guard < 20) begin
            step(1'b1);
            guard++;
        end
        checks_total++;
        if (press_pulse !== 1'b1) $display("FAIL midhold_press got %b expected 1", press_pulse);
        else checks_passed++;
        repeat (10) step(1'b1);
        rst_n = 1'b0;
        step(1'b1);
        checks_total++;
        if (dut_vec !== 12'h000)
            $display("FAIL midhold_reset_outputs got %h expected %h", dut_vec, 12'h000);
        else checks_passed++;
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1);
            checks_total++;
            if (dut_vec !== exp_vec)
                $display("FAIL midhold_model got %h expected %h", dut_vec, exp_vec);
            else checks_passed++;
            if (release_pulse) rel_seen = 1'b1;
            if (press_pulse && lat < 0) lat = i - 1;
        end
        checks_total++;
        if (rel_seen !== 1'b0) $display("FAIL midhold_no_release got %b expected 0", rel_seen);
        else checks_passed++;
        checks_total++;
        if (lat !== DEB + 2) $display("FAIL midhold_repress_latency got %0d expected %0d", lat, DEB + 2);
        else checks_passed++;
        repeat (12) step(1'b0);
    endtask

    task automatic test_random();
        int n = 0;
        logic lvl = 1'b0;
        while (n < 500) begin
            int len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                step(lvl);
                n++;
                checks_total++;
                if (dut_vec !== exp_vec)
                    $display("FAIL random_model got %h expected %h", dut_vec, exp_vec);
                else checks_passed++;
                checks_total++;
                if ((press_pulse + release_pulse + long_press) > 1)
                    $display("FAIL random_exclusive got %b%b%b expected at most one",
                             press_pulse, release_pulse, long_press);
                else checks_passed++;
            end
            lvl = !lvl;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_glitch();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the stable-input cycles needed to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100_000_000, giving the debounced-hold cycles that qualify a long press (1 s at 100 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port btn_raw, input, 1 bit: the asynchronous, bouncing pushbutton, active-high.
REQ-006 The block SHALL have port btn_level, output, 1 bit: the debounced button level.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: a one-cycle strobe on each accepted press.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: a one-cycle strobe on each accepted release.
REQ-009 The block SHALL have port long_press, output, 1 bit: a one-cycle strobe when a hold reaches LONG_CYCLES.
REQ-010 The block SHALL have port press_count, output, 8 bits: the number of accepted presses, modulo 256.

Function
REQ-011 btn_raw SHALL pass through a two-flop synchronizer; the FSM sees only the second-stage output btn_sync.
REQ-012 The FSM SHALL have four states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
REQ-013 RELEASED: on btn_sync=1, go to PRESS_CHK and clear the debounce counter.
REQ-014 PRESS_CHK: on btn_sync=0, return to RELEASED with no outputs (bounce rejected); otherwise increment the counter.
REQ-015 PRESS_CHK: on the cycle the counter equals DEBOUNCE_CYCLES-1 with btn_sync=1, go to PRESSED, pulse press_pulse, set btn_level=1, increment press_count, and clear the hold counter.
REQ-016 PRESSED: increment the 32-bit hold counter each cycle, saturating at LONG_CYCLES.
REQ-017 PRESSED: pulse long_press exactly once per press, on the cycle the hold counter reaches LONG_CYCLES-1.
REQ-018 PRESSED: on btn_sync=0, go to RELEASE_CHK and clear the debounce counter; the hold counter keeps running.
REQ-019 RELEASE_CHK: on btn_sync=1, return to PRESSED with the hold counter preserved and no outputs.
REQ-020 RELEASE_CHK: on the cycle the counter equals DEBOUNCE_CYCLES-1 with btn_sync=0, go to RELEASED, pulse release_pulse, and clear btn_level.
REQ-021 Latency from the first rising clk edge that samples btn_raw=1 to press_pulse high SHALL be DEBOUNCE_CYCLES+2 cycles, given a stable input; release latency SHALL be symmetric.
REQ-022 press_pulse, release_pulse and long_press SHALL be registered, one cycle wide, and never asserted in the same cycle.
REQ-023 press_count SHALL wrap from 255 to 0 with no flag.
REQ-024 btn_level SHALL change only in the same cycle as press_pulse or release_pulse.
REQ-025 The debounce and hold counters SHALL each be 32 bits wide; DEBOUNCE_CYCLES≥2 and LONG_CYCLES>DEBOUNCE_CYCLES are legal-parameter rules.

Reset
REQ-026 With rst_n=0 at a clk edge, the block SHALL enter state RELEASED with all counters, synchronizer flops and outputs at 0 (btn_level=0, pulses=0, press_count=0).
REQ-027 A reset asserted mid-press SHALL drop btn_level and emit no release_pulse.
REQ-028 After reset releases, a held button SHALL be re-debounced from RELEASED and produce a fresh press_pulse.

Structure
REQ-029 Package blink_pkg SHALL hold the FSM state enum and the default values of DEBOUNCE_CYCLES and LONG_CYCLES.
REQ-030 The synchronizer SHALL be a separate sub-module, sync2: 1-bit, two flops, reset to 0.
REQ-031 The implementation SHALL use no latches, no derived clocks and blocking-free sequential logic.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-032 Clean press: btn_raw 0→1 held 20 cycles -> press_pulse at cycle 6, btn_level=1, press_count=1.
REQ-033 Bounce rejection: btn_raw toggling with high periods of 1–3 cycles for 30 cycles, then 0 -> no pulse, btn_level stays 0.
REQ-034 Long press: hold 30 cycles -> exactly one long_press, 16 cycles after press_pulse; release -> release_pulse 6 cycles after btn_raw falls.
REQ-035 Release glitch: while pressed, btn_raw low for 2 cycles -> no release_pulse; btn_level stays 1; long_press timing unchanged.
REQ-036 Wrap: 257 clean presses -> press_count=1.
REQ-037 Reset mid-hold: rst_n low for 1 cycle at hold count 10 with button still high -> outputs 0, no release_pulse; a fresh press_pulse 6 cycles after reset deasserts.
